// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: triggered ADC record capture with per-lane scaling and 32-bit readout.
// Ports:
//   pl_clk, rst                    clock, asynchronous active-low reset
//   trigger                        capture request (rising edge starts a record in IDLE)
//   run_cycles, shift_val          record length in ADC words, per-sample arithmetic shift
//   s_axis_tdata/tvalid/tready     128-bit ADC input, eight signed 16-bit lanes
//   m_axis_tdata/tvalid/tready/tlast 32-bit readout, four beats per captured word
//   busy                           high while capturing or reading out
//   overflow                       sticky until next trigger; run_cycles exceeded DEPTH
module adc_capture_buffer #(
   parameter int DEPTH = 64,
   parameter int CFG_W = 32
) (
   input  logic             pl_clk,
   input  logic             rst,
   input  logic             trigger,
   input  logic [CFG_W-1:0] run_cycles,
   input  logic [CFG_W-1:0] shift_val,
   input  logic [127:0]     s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [31:0]      m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast,
   output logic             busy,
   output logic             overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;
   state_t state, state_nxt;
   logic trig_q, trig_rise, big, wr_en, wr_done, accept, last_beat;
   logic [AW:0] cnt, wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic [3:0] sh;
   logic [1:0] beat;
   logic [127:0] scaled, word_q;
   logic [127:0] mem [DEPTH];

   assign trig_rise = trigger & ~trig_q;
   assign big = run_cycles > CFG_W'(DEPTH);
   assign wr_nxt = wr_ptr + 1'b1;
   assign rd_nxt = rd_ptr + 1'b1;
   assign wr_en = state == CAPTURE && s_axis_tvalid;
   assign wr_done = wr_en && wr_nxt == cnt;
   assign accept = m_axis_tvalid && m_axis_tready;
   // rd_ptr indexes the word currently held in word_q
   assign last_beat = beat == 2'd3 && rd_nxt == cnt;
   assign m_axis_tlast = m_axis_tvalid && last_beat;
   assign m_axis_tdata = word_q[32*beat +: 32];
   assign busy = state != IDLE;

   // lanes are shifted independently so no sign bits leak across lane boundaries
   always_comb begin
      scaled = '0;
      for (int i = 0; i < 8; i++)
         scaled[16*i +: 16] = $signed(s_axis_tdata[16*i +: 16]) >>> sh;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = trig_rise && run_cycles != '0 ? CAPTURE : IDLE;
         CAPTURE: state_nxt = wr_done ? READOUT : CAPTURE;
         READOUT: state_nxt = accept && last_beat ? IDLE : READOUT;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pl_clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nxt;

   always_ff @(posedge pl_clk)
      if (wr_en) mem[wr_ptr[AW-1:0]] <= scaled;

   always_ff @(posedge pl_clk or negedge rst)
      if (!rst) begin
         trig_q <= 1'b0;
         s_axis_tready <= 1'b0;
         overflow <= 1'b0;
         cnt <= '0;
         sh <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         beat <= '0;
         word_q <= '0;
         m_axis_tvalid <= 1'b0;
      end else begin
         trig_q <= trigger;
         s_axis_tready <= 1'b1;
         if (state == IDLE && trig_rise) begin
            overflow <= big;
            cnt <= big ? FULL : run_cycles[AW:0];
            sh <= shift_val > CFG_W'(15) ? 4'd15 : shift_val[3:0];
            wr_ptr <= '0;
         end
         if (wr_en) wr_ptr <= wr_nxt;
         if (wr_done) begin
            rd_ptr <= '0;
            beat <= '0;
         end
         // word 0 is fetched on the first READOUT cycle; later words are fetched
         // on the accept of beat 3 so the stream has no bubbles between words
         if (state == READOUT) begin
            if (!m_axis_tvalid) begin
               word_q <= mem[rd_ptr[AW-1:0]];
               m_axis_tvalid <= 1'b1;
            end else if (accept) begin
               beat <= beat + 2'd1;
               if (last_beat) m_axis_tvalid <= 1'b0;
               else if (beat == 2'd3) begin
                  rd_ptr <= rd_nxt;
                  word_q <= mem[rd_nxt[AW-1:0]];
               end
            end
         end
      end
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: scoreboard bench for adc_capture_buffer (DEPTH = 8).
module tb_adc_capture_buffer;
   localparam int DEPTH = 8;
   logic pl_clk, rst, trigger, s_axis_tvalid, s_axis_tready;
   logic [31:0] run_cycles, shift_val, m_axis_tdata;
   logic [127:0] s_axis_tdata;
   logic m_axis_tvalid, m_axis_tready, m_axis_tlast, busy, overflow;

   adc_capture_buffer #(.DEPTH(DEPTH), .CFG_W(32)) dut (
      .pl_clk(pl_clk), .rst(rst), .trigger(trigger),
      .run_cycles(run_cycles), .shift_val(shift_val),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .busy(busy), .overflow(overflow)
   );

   initial pl_clk = 1'b0;
   always #5 pl_clk = ~pl_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int acc_cnt = 0;
   logic [32:0] exp_q[$];
   logic [127:0] src[$];
   logic [127:0] w_basic;
   bit toggle = 0;
   bit held = 0;
   logic [31:0] held_d;
   logic held_l;
   logic [32:0] e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h need %h", name, act, req);
      end
   endtask

   // monitor: checks every accepted beat against the scoreboard and that stalled beats hold
   always @(negedge pl_clk) begin
      if (!rst) held = 0;
      else begin
         if (held) begin
            n_cmp++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_d || m_axis_tlast !== held_l) begin
               n_bad++;
               $display("FAIL stall_hold: got v=%b d=%h l=%b need v=1 d=%h l=%b",
                        m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_d, held_l);
            end
         end
         held = m_axis_tvalid && !m_axis_tready;
         held_d = m_axis_tdata;
         held_l = m_axis_tlast;
         if (m_axis_tvalid && m_axis_tready) begin
            acc_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_beat: got d=%h l=%b need no beat", m_axis_tdata, m_axis_tlast);
            end else begin
               e = exp_q.pop_front();
               if ({m_axis_tlast, m_axis_tdata} !== e) begin
                  n_bad++;
                  $display("FAIL beat: got d=%h l=%b need d=%h l=%b", m_axis_tdata, m_axis_tlast, e[31:0], e[32]);
               end
            end
         end
      end
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge pl_clk);
         #1 m_axis_tready = toggle ? ~m_axis_tready : 1'b1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish need finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] mk_word(input int k);
      logic [127:0] w;
      for (int i = 0; i < 8; i++) w[16*i +: 16] = 16'((i % 2 == 0 ? 32'hA000 : 32'h2000) + k * 16 + i);
      return w;
   endfunction

   function automatic logic [127:0] scale(input logic [127:0] w, input int s);
      logic [127:0] r;
      int c;
      c = s > 15 ? 15 : s;
      for (int i = 0; i < 8; i++) r[16*i +: 16] = $signed(w[16*i +: 16]) >>> c;
      return r;
   endfunction

   task automatic push_beats(input logic [31:0] b0, b1, b2, b3, input bit last);
      exp_q.push_back({1'b0, b0});
      exp_q.push_back({1'b0, b1});
      exp_q.push_back({1'b0, b2});
      exp_q.push_back({last, b3});
   endtask

   task automatic push_model(input int n, input int s);
      logic [127:0] w;
      for (int k = 0; k < n; k++) begin
         w = scale(src[k], s);
         push_beats(w[31:0], w[63:32], w[95:64], w[127:96], k == n - 1);
      end
   endtask

   task automatic fill_src(input int n, input int base);
      src.delete();
      for (int k = 0; k < n; k++) src.push_back(mk_word(base + k));
   endtask

   // trigger rises, junk is offered in IDLE, then n words with optional gaps, then tail junk
   task automatic capture(input int n, input bit gap, input bit retrig, input int tail);
      @(posedge pl_clk); #1;
      trigger = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = {8{16'hDEAD}};
      @(posedge pl_clk); #1;
      for (int k = 0; k < n; k++) begin
         if (retrig && k == 1) trigger = 1'b0;
         if (retrig && k == 2) trigger = 1'b1;
         s_axis_tdata = src[k];
         s_axis_tvalid = 1'b1;
         @(posedge pl_clk); #1;
         if (gap) begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata = {8{16'hBAD0}};
            @(posedge pl_clk); #1;
         end
      end
      s_axis_tdata = {8{16'h5A5A}};
      s_axis_tvalid = tail > 0;
      repeat (tail) begin
         @(posedge pl_clk); #1;
      end
      s_axis_tvalid = 1'b0;
      if (!retrig) trigger = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 3000) begin
         @(posedge pl_clk); #1;
         n++;
      end
      chk({name, "_pending"}, exp_q.size(), 0);
      chk({name, "_busy"}, busy, 0);
      exp_q.delete();
      repeat (3) @(posedge pl_clk);
      #1;
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_tready"}, s_axis_tready, 0);
      chk({name, "_tdata"}, m_axis_tdata, 0);
      chk({name, "_tvalid"}, m_axis_tvalid, 0);
      chk({name, "_tlast"}, m_axis_tlast, 0);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_overflow"}, overflow, 0);
   endtask

   initial begin
      int n, base;
      rst = 1'b0;
      trigger = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;
      run_cycles = '0;
      shift_val = '0;
      w_basic = {16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h5000, 16'h6000, 16'h7000, 16'h8000};
      #1 chk_reset("reset");
      repeat (3) @(posedge pl_clk);
      #1 rst = 1'b1;
      @(posedge pl_clk); #1;
      chk("tready_after_reset", s_axis_tready, 1);

      // basic record, shift 2, with latency and throughput checks
      run_cycles = 4;
      shift_val = 2;
      src.delete();
      repeat (4) src.push_back(w_basic);
      for (int k = 0; k < 4; k++) push_beats(32'h1C00E000, 32'h14001800, 32'h0C001000, 32'h04000800, k == 3);
      capture(4, 0, 0, 0);
      n = 0;
      while (!m_axis_tvalid && n < 20) begin
         @(posedge pl_clk); #1;
         n++;
      end
      chk("first_valid_latency", n, 1);
      n = 0;
      while (busy && n < 40) begin
         @(posedge pl_clk); #1;
         n++;
      end
      chk("record_cycles", n, 16);
      wait_done("basic");

      // shift 0
      run_cycles = 1;
      shift_val = 0;
      src.delete();
      src.push_back(w_basic);
      push_beats(32'h70008000, 32'h50006000, 32'h30004000, 32'h10002000, 1);
      capture(1, 0, 0, 2);
      wait_done("shift0");

      // shift 40 clamps to 15
      run_cycles = 2;
      shift_val = 40;
      src.delete();
      repeat (2) src.push_back(w_basic);
      for (int k = 0; k < 2; k++) push_beats(32'h0000FFFF, 32'h0, 32'h0, 32'h0, k == 1);
      capture(2, 0, 0, 0);
      wait_done("shift40");

      // backpressure
      toggle = 1;
      run_cycles = 5;
      shift_val = 3;
      fill_src(5, 0);
      push_model(5, 3);
      capture(5, 0, 0, 2);
      wait_done("backpressure");
      toggle = 0;

      // ADC gaps and ignored re-triggers
      run_cycles = 4;
      shift_val = 1;
      fill_src(4, 10);
      push_model(4, 1);
      capture(4, 1, 1, 0);
      repeat (2) @(posedge pl_clk);
      #1 trigger = 1'b0;
      repeat (2) @(posedge pl_clk);
      #1 trigger = 1'b1;
      repeat (2) @(posedge pl_clk);
      #1 trigger = 1'b0;
      wait_done("gaps");
      repeat (20) @(posedge pl_clk);
      #1 chk("no_second_record_busy", busy, 0);

      // overflow clamps to DEPTH
      run_cycles = DEPTH + 5;
      shift_val = 0;
      fill_src(DEPTH, 20);
      push_model(DEPTH, 0);
      capture(DEPTH, 0, 0, 5);
      chk("overflow_set", overflow, 1);
      wait_done("overflow");
      chk("overflow_sticky", overflow, 1);

      // zero count
      run_cycles = 0;
      capture(0, 0, 0, 0);
      chk("zero_busy", busy, 0);
      chk("overflow_cleared", overflow, 0);
      repeat (10) @(posedge pl_clk);
      #1 chk("zero_busy_later", busy, 0);

      // reset mid-readout, then a fresh record
      run_cycles = 4;
      shift_val = 0;
      fill_src(4, 40);
      push_model(4, 0);
      base = acc_cnt;
      capture(4, 0, 0, 0);
      n = 0;
      while (acc_cnt - base < 5 && n < 100) begin
         @(posedge pl_clk); #1;
         n++;
      end
      chk("beats_before_reset", acc_cnt - base, 5);
      rst = 1'b0;
      #1 chk_reset("mid_reset");
      exp_q.delete();
      repeat (2) @(posedge pl_clk);
      #1 rst = 1'b1;
      run_cycles = 3;
      shift_val = 5;
      fill_src(3, 50);
      push_model(3, 5);
      capture(3, 0, 0, 0);
      wait_done("after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
